button_conditioner: RTL and testbench
=====================================

# button_conditioner

Synchronises, debounces and edge-detects raw board push-buttons in the `sysclk` domain. Produces clean levels, one-cycle press/release pulses and a long-press reset request. The reset request drives the `button` input of the board clock/reset generator, so a held button 0 restarts the machine. The levels and pulses feed the coin/start/throw control inputs.

## Interface
- `NUM_BTN`, 4: number of buttons; bit 0 is the reset button.
- `DEBOUNCE_CYCLES`, 50000: consecutive `sysclk` cycles a new synchronised value must persist before the debounced level changes; minimum 2.
- `LONG_CYCLES`, 25000000: cycles button 0 must be held, debounced, before `reset_req` asserts; minimum 1.
- `REPEAT_DELAY`, 12500000: hold time before the first auto-repeat press. Used only with `BTN_AUTOREPEAT_EN`.
- `REPEAT_PERIOD`, 2500000: interval between subsequent auto-repeat presses. Used only with `BTN_AUTOREPEAT_EN`.

Ports:
- `sysclk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `btn_in`  in  NUM_BTN  raw asynchronous buttons; 1 = pressed.
- `btn_level`  out  NUM_BTN  debounced level.
- `btn_press`  out  NUM_BTN  one-cycle pulse on each press event.
- `btn_release`  out  NUM_BTN  one-cycle pulse on each debounced 1→0 transition.
- `reset_req`  out  1  long-press request on button 0; level signal.

## Operation
- **Reset values.** Every output is 0 during and after `reset`. Synchroniser flops, debounce counters, long counter and repeat counter are all cleared.
- **Synchroniser.** A two-flop synchroniser on each `btn_in` bit produces `s[i]`.
- **Debounce counter.** Each button has its own counter, width clog2(DEBOUNCE_CYCLES+1).
  - Each cycle with `s[i]==btn_level[i]`: the counter clears.
  - Otherwise the counter increments.
  - On the cycle it would reach `DEBOUNCE_CYCLES`: `btn_level[i]` toggles and the counter clears.
- **Glitch rejection.** A raw pulse or gap shorter than `DEBOUNCE_CYCLES` cycles after synchronisation never changes `btn_level`.
- **Edge pulses.** `btn_press[i]` and `btn_release[i]` are registered with `btn_level[i]`. Each is high exactly during the first cycle of the new level.
- **Long press.** A 26-bit saturating counter runs while `btn_level[0]==1`.
  - It clears on any cycle with `btn_level[0]==0`.
  - `reset_req` goes to 1 on the cycle the count reaches `LONG_CYCLES`.
  - `reset_req` stays 1 while held and drops together with `btn_level[0]`.
- **Button independence.** Buttons are fully independent; simultaneous transitions on several bits all produce their pulses in the same cycle.
- **Reset mid-operation.** `reset` aborts any pending debounce, long-press or repeat count.
  - A button held through reset is treated as a fresh press after reset releases.

## Timing
- **Debounce latency.** Raw change captured at edge k → `btn_level` changes after edge k+1+DEBOUNCE_CYCLES, i.e. DEBOUNCE_CYCLES+2 edges.
- **Long-press latency.** `reset_req` asserts `LONG_CYCLES` edges after the edge that set `btn_level[0]`.
- **Counter saturation.** Counters saturate; a button held indefinitely never wraps `reset_req` or the repeat timing.
- **Release.** `reset_req` and `btn_level[0]` fall on the same edge.
- **Output registers.** All outputs are driven directly from flops; no combinational path from `btn_in`.

## Configuration
- **`BTN_AUTOREPEAT_EN` defined.** Per button, while `btn_level[i]` is held:
  - an extra one-cycle `btn_press[i]` is issued `REPEAT_DELAY` cycles after the initial press;
  - then one every `REPEAT_PERIOD` cycles until release;
  - release clears the repeat counter, and no repeat pulse is issued on the release cycle.
- **`BTN_AUTOREPEAT_EN` undefined.** Exactly one `btn_press` per debounced 0→1 transition. No repeat logic is synthesised, and `REPEAT_*` are ignored.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=8, LONG_CYCLES=100, REPEAT_DELAY=40, REPEAT_PERIOD=10.
- **Clean press.** Raise `btn_in[1]` and hold → `btn_level[1]` rises exactly 10 edges later; `btn_press[1]` high 1 cycle; nothing on other bits.
- **Bounce.** `btn_in[2]` toggles with 3-cycle high/low pulses for 60 cycles, then stays 1 → no pulse during the bounce; a single `btn_press[2]` 10 edges after the final rise.
- **Long press.** Hold `btn_in[0]` for 200 cycles, then release.
  - `reset_req` rises 100 edges after `btn_level[0]`.
  - On release, `reset_req` and `btn_level[0]` fall together and `btn_release[0]` pulses once.
- **Reset mid-operation.** Hold `btn_in[3]`; assert `reset` for 5 cycles at count 5 of debounce → all outputs 0 during reset; `btn_press[3]` appears 10 edges after reset deasserts.
- **Simultaneous buttons.** Raise `btn_in[3:0]=4'hF` on one edge → all four `btn_press` bits pulse in the same cycle.
- **Auto-repeat (`BTN_AUTOREPEAT_EN`).** Hold `btn_in[1]` for 80 cycles after debounce.
  - With the macro: presses at offsets 0, 40, 50, 60, 70.
  - Without the macro: only the press at offset 0.

Source files
------------

// File: rtl/button_conditioner.sv
// button_conditioner: two-flop sync, per-button debounce, press/release pulses, long-press reset_req on button 0.
// Define BTN_AUTOREPEAT_EN to add auto-repeat presses while a button is held.
module button_conditioner #(
  parameter int NUM_BTN = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int LONG_CYCLES = 25000000,
  parameter int REPEAT_DELAY = 12500000,
  parameter int REPEAT_PERIOD = 2500000
) (
  input  logic               sysclk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_in,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic               reset_req
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [25:0] LONG_LAST = 26'(LONG_CYCLES - 1);
  logic [NUM_BTN-1:0] s1, s, flip, level_next, rep;
  logic [DW-1:0] cnt [NUM_BTN];
  logic [25:0] long_cnt;
  always_comb begin
    flip = '0;
    for (int i = 0; i < NUM_BTN; i++) flip[i] = s[i] != btn_level[i] && cnt[i] == DB_LAST;
  end
  assign level_next = btn_level ^ flip;
  always_ff @(posedge sysclk) begin
    if (reset) begin
      s1 <= '0;
      s <= '0;
      btn_level <= '0;
      btn_press <= '0;
      btn_release <= '0;
      for (int i = 0; i < NUM_BTN; i++) cnt[i] <= '0;
    end else begin
      s1 <= btn_in;
      s <= s1;
      btn_level <= level_next;
      btn_press <= (flip & ~btn_level) | rep;
      btn_release <= flip & btn_level;
      for (int i = 0; i < NUM_BTN; i++) cnt[i] <= (s[i] == btn_level[i] || flip[i]) ? '0 : cnt[i] + 1'b1;
    end
  end
  // reset_req looks at the next level so it falls on the same edge as btn_level[0]
  always_ff @(posedge sysclk) begin
    if (reset) begin
      long_cnt <= '0;
      reset_req <= 1'b0;
    end else begin
      long_cnt <= !btn_level[0] ? '0 : long_cnt == LONG_LAST ? long_cnt : long_cnt + 1'b1;
      reset_req <= btn_level[0] && level_next[0] && long_cnt == LONG_LAST;
    end
  end
`ifdef BTN_AUTOREPEAT_EN
  localparam int RMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RMAX + 1);
  localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);
  logic [RW-1:0] rcnt [NUM_BTN];
  logic [NUM_BTN-1:0] first, held;
  assign held = btn_level & level_next;
  always_comb begin
    rep = '0;
    for (int i = 0; i < NUM_BTN; i++) rep[i] = held[i] && rcnt[i] == (first[i] ? RD_LAST : RP_LAST);
  end
  // counter restarts on each repeat, so it never exceeds the larger interval
  always_ff @(posedge sysclk) begin
    if (reset) begin
      first <= '1;
      for (int i = 0; i < NUM_BTN; i++) rcnt[i] <= '0;
    end else begin
      first <= ~held | (first & ~rep);
      for (int i = 0; i < NUM_BTN; i++) rcnt[i] <= (!held[i] || rep[i]) ? '0 : rcnt[i] + 1'b1;
    end
  end
`else
  assign rep = '0;
`endif
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed and random checks of button_conditioner against an edge-indexed behavioural model.
module tb_button_conditioner;
  localparam int NB = 4, D = 8, L = 100, RD = 40, RP = 10, MAXE = 30000;
`ifdef BTN_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif
  logic sysclk = 1'b0, reset = 1'b1;
  logic [NB-1:0] btn_in = '0;
  logic [NB-1:0] btn_level, btn_press, btn_release;
  logic reset_req;
  int vectors = 0, errors = 0;

  button_conditioner #(.NUM_BTN(NB), .DEBOUNCE_CYCLES(D), .LONG_CYCLES(L),
                       .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .sysclk(sysclk), .reset(reset), .btn_in(btn_in), .btn_level(btn_level),
    .btn_press(btn_press), .btn_release(btn_release), .reset_req(reset_req));

  always #5 sysclk = ~sysclk;

  // model: synchronised samples indexed by edge number, rise edges and last level-change edges
  int edge_n = 0;
  bit m_valid = 1'b0;
  logic [NB-1:0] q1 = '0, q2 = '0, m_level = '0, m_press = '0, m_release = '0;
  logic m_req = 1'b0;
  logic [NB-1:0] svh [0:MAXE];
  int last_ev [NB];
  int rise [NB];

  always @(posedge sysclk) begin
    logic [NB-1:0] old;
    bit settled;
    int t;
    edge_n++;
    if (edge_n >= MAXE) begin
      $display("FAIL edge_budget edges=%0d limit=%0d", edge_n, MAXE);
      $fatal(1);
    end
    if (reset) begin
      q1 = '0; q2 = '0; m_level = '0; m_press = '0; m_release = '0; m_req = 1'b0;
      for (int i = 0; i < NB; i++) begin last_ev[i] = edge_n; rise[i] = edge_n; end
    end else begin
      old = m_level;
      svh[edge_n] = q2;
      q2 = q1;
      q1 = btn_in;
      for (int i = 0; i < NB; i++) begin
        settled = (edge_n - last_ev[i]) >= D;
        if (settled)
          for (int k = 0; k < D; k++) if (svh[edge_n - k][i] == old[i]) settled = 1'b0;
        if (settled) begin
          m_level[i] = ~old[i];
          last_ev[i] = edge_n;
          if (m_level[i]) rise[i] = edge_n;
        end
      end
      m_press = m_level & ~old;
      m_release = old & ~m_level;
      if (AR)
        for (int i = 0; i < NB; i++)
          if (old[i] && m_level[i]) begin
            t = edge_n - rise[i];
            if (t >= RD && (t - RD) % RP == 0) m_press[i] = 1'b1;
          end
      m_req = m_level[0] && (edge_n - rise[0]) >= L;
    end
    m_valid = 1'b1;
  end

  always @(negedge sysclk) if (m_valid) begin
    vectors++;
    if (btn_level !== m_level) begin errors++; $display("FAIL level edge=%0d got=%h want=%h", edge_n, btn_level, m_level); end
    if (btn_press !== m_press) begin errors++; $display("FAIL press edge=%0d got=%h want=%h", edge_n, btn_press, m_press); end
    if (btn_release !== m_release) begin errors++; $display("FAIL release edge=%0d got=%h want=%h", edge_n, btn_release, m_release); end
    if (reset_req !== m_req) begin errors++; $display("FAIL reset_req edge=%0d got=%b want=%b", edge_n, reset_req, m_req); end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  // kind 0: press pulse, 1: reset_req, 2: release pulse; returns negedges waited
  task automatic wait_for(input int kind, input int b, input int maxc, output int cyc);
    bit hit;
    cyc = 0;
    hit = 1'b0;
    while (!hit && cyc < maxc) begin
      @(negedge sysclk);
      cyc++;
      hit = kind == 0 ? btn_press[b] : kind == 1 ? reset_req : btn_release[b];
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog time=%0t limit=2000000", $time);
    $fatal(1);
  end

  initial begin
    int cyc, n;
    repeat (3) @(negedge sysclk);
    check("reset_state", {19'd0, btn_level, btn_press, btn_release, reset_req}, 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge sysclk);

    btn_in[1] = 1'b1;
    wait_for(0, 1, 30, cyc);
    check("clean_latency", cyc, 10);
    check("clean_press_bits", btn_press, 4'b0010);
    check("clean_level_bits", btn_level, 4'b0010);
    @(negedge sysclk);
    check("clean_press_width", btn_press, 4'b0000);
    btn_in[1] = 1'b0;
    wait_for(2, 1, 30, cyc);
    check("clean_release_latency", cyc, 10);
    repeat (4) @(negedge sysclk);

    n = 0;
    for (int c = 0; c < 60; c++) begin
      btn_in[2] = ((c / 3) % 2) == 0;
      @(negedge sysclk);
      if (btn_press[2] || btn_level[2]) n++;
    end
    check("bounce_quiet", n, 0);
    btn_in[2] = 1'b1;
    wait_for(0, 2, 30, cyc);
    check("bounce_latency", cyc, 10);
    btn_in[2] = 1'b0;
    repeat (15) @(negedge sysclk);

    btn_in[0] = 1'b1;
    wait_for(0, 0, 30, cyc);
    check("long_level_latency", cyc, 10);
    wait_for(1, 0, 150, cyc);
    check("long_req_latency", cyc, 100);
    repeat (90) @(negedge sysclk);
    btn_in[0] = 1'b0;
    repeat (9) @(negedge sysclk);
    check("long_req_held", {btn_level[0], reset_req}, 2'b11);
    @(negedge sysclk);
    check("long_fall_together", {btn_level[0], reset_req, btn_release[0]}, 3'b001);
    @(negedge sysclk);
    check("long_release_width", btn_release[0], 1'b0);
    repeat (4) @(negedge sysclk);

    btn_in[3] = 1'b1;
    repeat (7) @(negedge sysclk);
    reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge sysclk);
      check("reset_mid_outputs", {19'd0, btn_level, btn_press, btn_release, reset_req}, 32'd0);
    end
    reset = 1'b0;
    wait_for(0, 3, 30, cyc);
    check("reset_mid_latency", cyc, 10);
    btn_in[3] = 1'b0;
    repeat (15) @(negedge sysclk);

    btn_in = 4'hF;
    wait_for(0, 0, 30, cyc);
    check("simul_latency", cyc, 10);
    check("simul_press_bits", btn_press, 4'hF);
    btn_in = 4'h0;
    repeat (15) @(negedge sysclk);

    btn_in[1] = 1'b1;
    wait_for(0, 1, 30, cyc);
    check("repeat_first_latency", cyc, 10);
    n = 1;
    for (int off = 1; off < 80; off++) begin
      @(negedge sysclk);
      if (btn_press[1]) n++;
    end
    check("repeat_press_count", n, AR ? 5 : 1);
    btn_in[1] = 1'b0;
    repeat (15) @(negedge sysclk);

    for (int r = 0; r < 300; r++) begin
      btn_in = 4'($urandom);
      n = ($urandom_range(0, 9) == 0) ? $urandom_range(50, 150) : $urandom_range(1, 14);
      repeat (n) @(negedge sysclk);
      if ($urandom_range(0, 49) == 0) begin
        reset = 1'b1;
        repeat ($urandom_range(1, 3)) @(negedge sysclk);
        reset = 1'b0;
      end
    end
    btn_in = '0;
    repeat (20) @(negedge sysclk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
